// File: rtl/mul_sequencer.sv
// mul_sequencer: 32x32->64 unsigned shift-add multiplier controller.
// It owns no adder. It drives an external 32-bit adder through adder_a,
// adder_b and adder_cin, reads the sum back on adder_s, and steps through
// 32 shift-add iterations. The carry-out of the adder is rebuilt locally
// from bit 31, because the adder does not export one.
module mul_sequencer #(
  parameter int WIDTH = 32  // must match the external adder; only 32 is supported
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     adder_a,
  output logic [WIDTH-1:0]     adder_b,
  output logic                 adder_cin,
  input  logic [WIDTH-1:0]     adder_s
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   m;          // latched multiplicand
  logic [2*WIDTH-1:0] p;          // {partial sum, remaining multiplier bits}
  logic [CW-1:0]      cnt;        // iteration index, 0..WIDTH-1
  logic               cout;       // carry out of the external adder
  logic               accept;     // start seen while idle
  logic               last_iter;  // this edge performs the final iteration

  assign accept    = (state == IDLE) && start;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // The adder adds the multiplicand into the upper half only when the
  // current multiplier LSB is set; otherwise it passes the upper half through.
  assign adder_a   = p[2*WIDTH-1:WIDTH];
  assign adder_b   = p[0] ? m : '0;
  assign adder_cin = 1'b0;

  // Rebuild the carry out of the MSB: a carry leaves bit 31 when both
  // inputs are set, or when exactly one is set and the sum bit came out 0.
  assign cout = (adder_a[WIDTH-1] & adder_b[WIDTH-1]) |
                ((adder_a[WIDTH-1] ^ adder_b[WIDTH-1]) & ~adder_s[WIDTH-1]);

  // The product register is observed directly; it holds after completion.
  assign product = p;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: load the operands on an accepted start, then on every RUN
  // edge shift the new sum (with its carry) in from the top and drop the
  // consumed multiplier bit from the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= '0;
      p   <= '0;
      cnt <= '0;
    end else if (accept) begin
      m   <= op_a;
      p   <= {{WIDTH{1'b0}}, op_b};
      cnt <= '0;
    end else if (state == RUN) begin
      p   <= {cout, adder_s, p[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Testbench for mul_sequencer: directed corner cases plus 1000 random
// back-to-back multiplies compared against a plain 64-bit multiply.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] adder_a;
  logic [31:0] adder_b;
  logic        adder_cin;
  logic [31:0] adder_s;

  int errors = 0;
  int checks = 0;
  int done_count = 0;

  mul_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_cin (adder_cin),
    .adder_s   (adder_s)
  );

  // External 32-bit adder the sequencer drives.
  assign adder_s = adder_a + adder_b + {31'b0, adder_cin};

  always #5 clk = ~clk;

  // Count done pulses as seen at each rising edge.
  always @(posedge clk) begin
    if (done) done_count <= done_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; start is sampled at the next rising edge (E0).
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom;  // later operand changes must not matter
    op_b  = $urandom;
  endtask

  // Count rising edges until done is observed; bounded.
  task automatic wait_done(output int edges, output bit busy_ok, output bit seen);
    edges   = 0;
    busy_ok = 1'b1;
    seen    = 1'b0;
    while (edges < 40 && !seen) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
  endtask

  // Full multiply: launch, wait, compare against the reference product.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input string tag, output time t_done);
    logic [63:0] exp;
    int          edges;
    bit          busy_ok;
    bit          seen;
    int          d0;
    exp = {32'h0, a} * {32'h0, b};
    d0  = done_count;
    launch(a, b);
    wait_done(edges, busy_ok, seen);
    t_done = $time;
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(edges), 64'd32);
    check({tag, "_prod"}, product, exp);
    check({tag, "_busy_run"}, 64'({busy_ok, busy}), 64'b11);
    @(negedge clk);
    check({tag, "_busy_after"}, 64'({busy, done}), 64'b00);
    check({tag, "_ndone"}, 64'(done_count - d0), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time         t_done;
    time         t_prev;
    bit          ok;
    int          edges;
    bit          busy_ok;
    bit          seen;
    int          d0;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy_done", 64'({busy, done}), 64'b00);
    check("rst_product", product, 64'h0);
    check("rst_adder", {adder_a, adder_b}, 64'h0);
    check("rst_cin", 64'(adder_cin), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Small operands, then product must hold while idle.
    run_mul(32'd3, 32'd5, "small", t_done);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (product !== 64'h0F || busy || done) ok = 1'b0;
    end
    check("small_hold", 64'(ok), 64'd1);

    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max", t_done);
    run_mul(32'h0, 32'h1234_5678, "zero", t_done);
    run_mul(32'h8000_0000, 32'd2, "msb", t_done);
    run_mul(32'd1, 32'hDEAD_BEEF, "ident", t_done);

    // Start held high while busy must be ignored.
    start = 1'b1;
    op_a  = 32'd7;
    op_b  = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'hFFFF;
    op_b  = 32'hFFFF;
    wait_done(edges, busy_ok, seen);
    check("busy_start_lat", 64'(edges + 4), 64'd32);
    check("busy_start_prod", product, 64'd63);
    @(posedge clk);
    #1 start = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (busy || product !== 64'd63) ok = 1'b0;
    end
    check("busy_start_ignored", 64'(ok), 64'd1);

    // Reset mid-operation.
    launch(32'd100, 32'd200);
    repeat (9) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_status", 64'({busy, done}), 64'b00);
    check("midrst_product", product, 64'h0);
    check("midrst_adder_a", 64'(adder_a), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_count;
    repeat (40) @(negedge clk);
    check("midrst_no_done", 64'(done_count - d0), 64'd0);
    check("midrst_idle", 64'({busy, product}), 65'h0);
    run_mul(32'd6, 32'd7, "after_rst", t_done);

    // Random back-to-back multiplies, each at the first legal idle cycle.
    t_prev = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 50 == 0) ra = 32'hFFFF_FFFF;
      if (i % 70 == 1) rb = 32'h0;
      run_mul(ra, rb, $sformatf("rnd%0d", i), t_done);
      if (i > 0) check($sformatf("rnd%0d_spacing", i), 64'(t_done - t_prev), 64'd340);
      t_prev = t_done;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
